// File: rtl/asip16_pkg.sv
// ---------------------------------------------------------------------------
// asip16_pkg
//   Shared definitions for the ASIP16 sequential ALU.
//   - ALU opcode encodings (ALU_ADD .. ALU_MOD); 4'hC..4'hF are illegal.
//   - One-hot FSM state encodings for seq_alu.
//   - Bit positions of Z/N/C/V inside the 4-bit flags bus.
//   - Operating mode of the iterative multiply/divide core.
// ---------------------------------------------------------------------------
package asip16_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOT = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_ASR = 4'h8;
  localparam logic [3:0] ALU_MUL = 4'h9;
  localparam logic [3:0] ALU_DIV = 4'hA;
  localparam logic [3:0] ALU_MOD = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_EXEC = 3'b010,
    ST_DONE = 3'b100
  } alu_state_e;

  // flags = {Z, N, C, V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_MOD = 2'd2
  } md_mode_e;

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// ---------------------------------------------------------------------------
// seq_alu_muldiv_core
//   Shared iterator for unsigned shift-add multiply and restoring divide.
//   One iteration per cycle while step=1; W iterations per operation.
//   Ports:
//     clk, rst    clock and synchronous active-high reset
//     load        capture a, b and mode, clear accumulator/remainder/counter
//     step        perform one iteration
//     mode        MD_MUL (low W bits of a*b), MD_DIV (quotient), MD_MOD (remainder)
//     a, b        operands (multiplicand/multiplier or dividend/divisor)
//     done        high in the cycle whose step is the final iteration
//     result      value the selected result register takes after this step
// ---------------------------------------------------------------------------
module seq_alu_muldiv_core
  import asip16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  md_mode_e     mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  acc_q, acc_d;   // product accumulator
  logic [W-1:0]  rem_q, rem_d;   // partial remainder
  logic [W-1:0]  opa_q, opa_d;   // multiplicand, or dividend shifting out / quotient shifting in
  logic [W-1:0]  opb_q, opb_d;   // multiplier, or divisor
  logic [CW-1:0] cnt_q, cnt_d;
  md_mode_e      mode_q, mode_d;

  logic [W:0] rem_sh;
  logic [W:0] trial;

  always_comb begin
    acc_d  = acc_q;
    rem_d  = rem_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    // Bring the next dividend bit into the remainder and try subtracting.
    // Since rem < divisor, the difference fits in W bits when no borrow.
    rem_sh = {rem_q, opa_q[W-1]};
    trial  = rem_sh - {1'b0, opb_q};
    if (load) begin
      acc_d  = '0;
      rem_d  = '0;
      opa_d  = a;
      opb_d  = b;
      cnt_d  = '0;
      mode_d = mode;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (mode_q == MD_MUL) begin
        if (opb_q[0]) begin
          acc_d = acc_q + opa_q;
        end
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else begin
        if (!trial[W]) begin
          rem_d = trial[W-1:0];
          opa_d = {opa_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          opa_d = {opa_q[W-2:0], 1'b0};
        end
      end
    end
  end

  assign done = step && (cnt_q == CW'(W - 1));

  always_comb begin
    case (mode_q)
      MD_MUL:  result = acc_d;
      MD_DIV:  result = opa_d;
      default: result = rem_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      rem_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MD_MUL;
    end else begin
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//   Multi-cycle 16-bit ALU for the ASIP16 datapath. The control unit issues a
//   one-cycle start; the block answers with a one-cycle ack.
//   Handshake: start is accepted only when the FSM is in IDLE (busy=0); a
//   start while busy is dropped. Operands/opcode are captured on the accepting
//   edge. ack is high exactly one cycle; result is valid from that cycle until
//   the next accepted start; flags change only on entry to the ack cycle.
//   Ports:
//     clk, rst_b   clock and synchronous active-high reset
//     start        launch pulse
//     alu_op       opcode (asip16_pkg ALU_*)
//     a, b         operands
//     result       registered result
//     flags        {Z,N,C,V}
//     ack          completion pulse
//     busy         high from the cycle after an accepted start through ack
//     err          illegal opcode or divide-by-zero, shown with ack
//   Configuration macro: SEQ_ALU_MULDIV_EN enables MUL/DIV/MOD (opcodes 9/A/B)
//   through seq_alu_muldiv_core; without it those opcodes are illegal.
// ---------------------------------------------------------------------------
module seq_alu
  import asip16_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [3:0]   alu_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic         ack,
  output logic         busy,
  output logic         err
);

  alu_state_e   state_q, state_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  // Single-cycle datapath, evaluated directly on the inputs in the accept cycle.
  logic [3:0]   sh;
  logic [W:0]   add_w, sub_w, shl_w, shr_w, asr_w;
  logic [W-1:0] sc_res;
  logic         sc_c, sc_v, sc_err;
  logic         is_iter;

  assign sh    = b[3:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  // Shifts carry one extra bit so the last bit shifted out lands in it.
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;
  assign asr_w = $unsigned($signed({a, 1'b0}) >>> sh);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        sc_res = add_w[W-1:0];
        sc_c   = add_w[W];
        sc_v   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        sc_res = sub_w[W-1:0];
        sc_c   = ~sub_w[W];
        sc_v   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
      end
      ALU_AND: sc_res = a & b;
      ALU_OR:  sc_res = a | b;
      ALU_XOR: sc_res = a ^ b;
      ALU_NOT: sc_res = ~a;
      ALU_SHL: begin
        sc_res = shl_w[W-1:0];
        sc_c   = shl_w[W];
      end
      ALU_SHR: begin
        sc_res = shr_w[W:1];
        sc_c   = shr_w[0];
      end
      ALU_ASR: begin
        sc_res = asr_w[W:1];
        sc_c   = asr_w[0];
      end
`ifdef SEQ_ALU_MULDIV_EN
      // Only reached for a zero divisor; non-zero divisors iterate.
      ALU_DIV: begin
        sc_res = '1;
        sc_err = 1'b1;
      end
      ALU_MOD: begin
        sc_res = a;
        sc_err = 1'b1;
      end
`endif
      default: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic         core_load, core_step, core_done;
  logic [W-1:0] core_result;
  md_mode_e     core_mode;

  assign is_iter = (alu_op == ALU_MUL) ||
                   (((alu_op == ALU_DIV) || (alu_op == ALU_MOD)) && (b != '0));

  always_comb begin
    case (alu_op)
      ALU_DIV: core_mode = MD_DIV;
      ALU_MOD: core_mode = MD_MOD;
      default: core_mode = MD_MUL;
    endcase
  end

  assign core_load = (state_q == ST_IDLE) && start && is_iter;
  assign core_step = (state_q == ST_EXEC);

  seq_alu_muldiv_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst_b),
    .load   (core_load),
    .step   (core_step),
    .mode   (core_mode),
    .a      (a),
    .b      (b),
    .done   (core_done),
    .result (core_result)
  );
`else
  assign is_iter = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (is_iter) begin
            state_d = ST_EXEC;
          end else begin
            state_d        = ST_DONE;
            ack_d          = 1'b1;
            result_d       = sc_res;
            err_d          = sc_err;
            flags_d[FLG_Z] = (sc_res == '0);
            flags_d[FLG_N] = sc_res[W-1];
            flags_d[FLG_C] = sc_c;
            flags_d[FLG_V] = sc_v;
          end
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      ST_EXEC: begin
        busy_d = 1'b1;
        if (core_done) begin
          state_d        = ST_DONE;
          ack_d          = 1'b1;
          result_d       = core_result;
          flags_d[FLG_Z] = (core_result == '0);
          flags_d[FLG_N] = core_result[W-1];
          flags_d[FLG_C] = 1'b0;
          flags_d[FLG_V] = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign ack    = ack_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
//   Directed testbench for seq_alu. Inputs change on the falling edge,
//   outputs are sampled on the falling edge. Latency is counted in rising
//   edges from the accepting edge (1 for single-cycle ops, 17 for MUL/DIV/MOD).
// ---------------------------------------------------------------------------
module tb_seq_alu;
  import asip16_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         ack;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  seq_alu #(.W(W)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .result (result),
    .flags  (flags),
    .ack    (ack),
    .busy   (busy),
    .err    (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one start pulse, then wait (bounded) for ack; lat=-1 on timeout
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, output int lat);
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack) lat = -1;
  endtask

  // directed vectors: op, a, b, expected result, expected {Z,N,C,V}
  localparam int NV = 16;
  localparam logic [3:0] V_OP [NV] = '{ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB,
                                       ALU_SUB, ALU_AND, ALU_OR,  ALU_XOR,
                                       ALU_NOT, ALU_SHL, ALU_SHL, ALU_SHR,
                                       ALU_SHR, ALU_ASR, ALU_ASR, ALU_ADD};
  localparam logic [15:0] V_A [NV] = '{16'h7FFF, 16'h0005, 16'hFFFF, 16'h0003,
                                       16'h8000, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                                       16'hFFFF, 16'h8001, 16'h1234, 16'h8003,
                                       16'h8000, 16'h8004, 16'h8002, 16'h1234};
  localparam logic [15:0] V_B [NV] = '{16'h0001, 16'h0005, 16'h0001, 16'h0005,
                                       16'h0001, 16'h3C3C, 16'h3C3C, 16'h3C3C,
                                       16'h1234, 16'h0001, 16'h0014, 16'h0001,
                                       16'h0000, 16'h0002, 16'h0002, 16'h4321};
  localparam logic [15:0] V_R [NV] = '{16'h8000, 16'h0000, 16'h0000, 16'hFFFE,
                                       16'h7FFF, 16'h3030, 16'hFCFC, 16'hCCCC,
                                       16'h0000, 16'h0002, 16'h2340, 16'h4001,
                                       16'h8000, 16'hE001, 16'hE000, 16'h5555};
  localparam logic [3:0] V_F [NV] = '{4'b0101, 4'b1010, 4'b1010, 4'b0100,
                                      4'b0011, 4'b0000, 4'b0100, 4'b0100,
                                      4'b1000, 4'b0010, 4'b0010, 4'b0010,
                                      4'b0100, 4'b0100, 4'b0110, 4'b0000};

  task automatic test_reset();
    rst_b = 1'b1; start = 1'b1; alu_op = ALU_ADD; a = 16'h0001; b = 16'h0002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ack, busy, err, flags, result} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: ack=%b busy=%b err=%b flags=%b result=%h, required all 0",
                 i, ack, busy, err, flags, result);
      end
    end
    rst_b = 1'b0;  // start still high: first edge after release must accept it
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (ack !== 1'b1 || result !== 16'h0003) begin
      n_fail++;
      $display("FAIL reset_first_start: ack=%b result=%h, required ack=1 result=0003", ack, result);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_vectors();
    int lat;
    logic [W-1:0] exp_r;
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(V_R[i]);
      run_op(V_OP[i], V_A[i], V_B[i], lat);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (lat != 1 || result !== exp_r || flags !== V_F[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d op=%h: lat=%0d result=%h flags=%b err=%b, required lat=1 result=%h flags=%b err=0",
                 i, V_OP[i], lat, result, flags, err, exp_r, V_F[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int lat;
`ifdef SEQ_ALU_MULDIV_EN
    logic [3:0] ill [2] = '{4'hE, 4'hF};
`else
    logic [3:0] ill [5] = '{4'hE, 4'hF, 4'h9, 4'hA, 4'hB};
`endif
    foreach (ill[i]) begin
      run_op(ill[i], 16'h1234, 16'h0005, lat);
      n_checks++;
      if (lat != 1 || result !== 16'h0000 || err !== 1'b1 || flags !== 4'b1000) begin
        n_fail++;
        $display("FAIL illegal op=%h: lat=%0d result=%h err=%b flags=%b, required lat=1 result=0000 err=1 flags=1000",
                 ill[i], lat, result, err, flags);
      end
    end
    // err must clear on the next accepted start
    run_op(ALU_OR, 16'h0100, 16'h0001, lat);
    n_checks++;
    if (lat != 1 || err !== 1'b0 || result !== 16'h0101) begin
      n_fail++;
      $display("FAIL err_clear: lat=%0d err=%b result=%h, required lat=1 err=0 result=0101", lat, err, result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; alu_op = ALU_ADD; a = 16'h0001; b = 16'h0002;
    @(negedge clk);  // edge N accepted
    n_checks++;
    if (ack !== 1'b1 || result !== 16'h0003 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: ack=%b busy=%b result=%h, required ack=1 busy=1 result=0003", ack, busy, result);
    end
    alu_op = ALU_SUB; a = 16'h000A; b = 16'h0004;  // start stays high in the ack cycle
    @(negedge clk);  // edge N+1: DONE, start ignored
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || result !== 16'h0003) begin
      n_fail++;
      $display("FAIL b2b_ignored_in_done: ack=%b busy=%b result=%h, required ack=0 busy=0 result=0003",
               ack, busy, result);
    end
    @(negedge clk);  // edge N+2: IDLE, accepted
    start = 1'b0;
    n_checks++;
    if (ack !== 1'b1 || result !== 16'h0006 || flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL b2b_second: ack=%b result=%h flags=%b, required ack=1 result=0006 flags=0010",
               ack, result, flags);
    end
    a = 16'hFFFF; b = 16'hFFFF; alu_op = ALU_AND;  // changes with no start have no effect
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0 || result !== 16'h0006) begin
      n_fail++;
      $display("FAIL b2b_hold: ack=%b busy=%b result=%h, required ack=0 busy=0 result=0006", ack, busy, result);
    end
  endtask

`ifdef SEQ_ALU_MULDIV_EN
  task automatic test_muldiv();
    int lat;
    int bcnt;
    logic [3:0]  m_op  [5] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD, ALU_MUL};
    logic [15:0] m_a   [5] = '{16'd1000, 16'd1000, 16'd1000, 16'h1234, 16'hFFFF};
    logic [15:0] m_b   [5] = '{16'd7, 16'd7, 16'd0, 16'd0, 16'hFFFF};
    logic [15:0] m_r   [5] = '{16'd142, 16'd6, 16'hFFFF, 16'h1234, 16'h0001};
    int          m_lat [5] = '{17, 17, 1, 1, 17};
    logic        m_err [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // MUL with a stray start at N+5
    @(negedge clk);
    start = 1'b1; alu_op = ALU_MUL; a = 16'd300; b = 16'd200;
    @(negedge clk);
    start = 1'b0; lat = 1; bcnt = busy ? 1 : 0;
    a = 16'h0000; b = 16'h0000;
    while (!ack && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; alu_op = ALU_ADD; a = 16'h0001; b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    n_checks++;
    if (lat != 17 || bcnt != 17 || result !== 16'hEA60 || flags !== 4'b0100 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_300x200: lat=%0d busy_cycles=%0d result=%h flags=%b err=%b, required 17/17 EA60 0100 0",
               lat, bcnt, result, flags, err);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_no_queue: ack=%b busy=%b, required 0/0", ack, busy);
    end
    for (int i = 0; i < 5; i++) begin
      run_op(m_op[i], m_a[i], m_b[i], lat);
      n_checks++;
      if (lat != m_lat[i] || result !== m_r[i] || err !== m_err[i]) begin
        n_fail++;
        $display("FAIL muldiv%0d op=%h: lat=%0d result=%h err=%b, required lat=%0d result=%h err=%b",
                 i, m_op[i], lat, result, err, m_lat[i], m_r[i], m_err[i]);
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    int lat;
    int acks;
    acks = 0;
    @(negedge clk);
`ifdef SEQ_ALU_MULDIV_EN
    start = 1'b1; alu_op = ALU_MUL; a = 16'd300; b = 16'd200;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    rst_b = 1'b1;  // sampled at edge N+8
`else
    // single-cycle op: reset on the very accepting edge suppresses the ack
    start = 1'b1; alu_op = ALU_ADD; a = 16'h0001; b = 16'h0001;
    rst_b = 1'b1;
`endif
    @(negedge clk);
    start = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    n_checks++;
    if (acks != 0 || busy !== 1'b0 || dut.state_q !== ST_IDLE || result !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_abort: acks=%0d busy=%b state=%b result=%h, required 0 0 001 0000",
               acks, busy, dut.state_q, result);
    end
    run_op(ALU_ADD, 16'h1000, 16'h0234, lat);
    n_checks++;
    if (lat != 1 || result !== 16'h1234 || flags !== 4'b0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_recover: lat=%0d result=%h flags=%b err=%b, required 1 1234 0000 0",
               lat, result, flags, err);
    end
  endtask

  initial begin
    rst_b = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    test_reset();
    test_alu_vectors();
    test_illegal();
    test_back_to_back();
`ifdef SEQ_ALU_MULDIV_EN
    test_muldiv();
`endif
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
